// File: rtl/mux_n_to_1_reg_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the registered N-to-1 selector (mux_n_to_1_reg) and
// its round-robin arbiter.
//
// Contents:
//   MODE_EXPLICIT / MODE_RR : encodings of the `mode` input.
//   sel_idx_t convention    : every module that handles channel indices declares
//                             `typedef logic [SEL_W-1:0] sel_idx_t;` locally,
//                             because SEL_W depends on the module's own N.
//   wrap_inc()              : index increment modulo n, used for the RR pointer.
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  // Next index after `idx` in a ring of `n` entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_n_to_1_reg_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin search: returns the first requesting
// channel found by scanning cyclically upward starting at `ptr`.
//
// Ports:
//   req       [N-1:0]      : per-channel request (the channel valids)
//   ptr       [SEL_W-1:0]  : search start index, always < N
//   grant_idx [SEL_W-1:0]  : granted channel (0 when grant_vld=0)
//   grant_vld              : at least one channel is requesting
// -----------------------------------------------------------------------------
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);

  typedef logic [SEL_W-1:0] sel_idx_t;

  always_comb begin
    int       idx;
    sel_idx_t idx_s;
    // NOTE: every output of a combinational block gets a default first so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    idx_s     = '0;
    for (int k = 0; k < N; k++) begin
      // ptr + k wrapped into 0..N-1 (ptr < N, k < N, so one subtract suffices)
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      idx_s = sel_idx_t'(idx);
      if (!grant_vld && req[idx_s]) begin
        grant_vld = 1'b1;
        grant_idx = idx_s;
      end
    end
  end

endmodule

// File: rtl/mux_n_to_1_reg.sv
// -----------------------------------------------------------------------------
// mux_n_to_1_reg
// Registered N-to-1 selector with valid/ready on every input channel and on the
// output. One result is held in the output register; a new input is accepted
// whenever that register is empty or being drained in the same cycle.
//
// Build option:
//   MUX_RR_EN defined   : `mode`=1 selects round-robin among valid channels.
//   MUX_RR_EN undefined : `mode` is ignored (explicit select only); the RR
//                         pointer and arbiter are not built.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_data  [N*WIDTH-1:0]   : channel i at [i*WIDTH +: WIDTH]
//   in_valid [N-1:0]         : per-channel valid
//   in_ready [N-1:0]         : per-channel ready, at most one bit high
//   sel      [SEL_W-1:0]     : explicit channel select (mode=0)
//   mode                     : 0 explicit, 1 round-robin
//   out_data [WIDTH-1:0]     : registered selected data
//   out_chan [SEL_W-1:0]     : channel that produced out_data
//   out_valid, out_ready     : output handshake
//   sel_err                  : sticky, set by an out-of-range sel in explicit mode
// -----------------------------------------------------------------------------
module mux_n_to_1_reg
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  typedef logic [SEL_W-1:0] sel_idx_t;

  logic             slot_free;
  logic             sel_in_range;
  logic             sel_chan_vld;
  logic             act_mode;
  logic             grant_vld;
  logic             transfer;
  sel_idx_t         grant_idx;
  logic [WIDTH-1:0] grant_data;

  // Output register can take new data if empty or being consumed this cycle.
  assign slot_free = !out_valid || out_ready;

  // Widened by one bit so the compare is meaningful when N is a power of 2.
  assign sel_in_range = {1'b0, sel} < (SEL_W + 1)'(N);

  // in_valid[sel] without indexing past N-1 when sel is out of range.
  always_comb begin
    sel_chan_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == sel_idx_t'(i)) sel_chan_vld = in_valid[i];
    end
  end

`ifdef MUX_RR_EN
  sel_idx_t rr_ptr;
  sel_idx_t rr_grant_idx;
  logic     rr_grant_vld;

  assign act_mode = mode;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .grant_idx (rr_grant_idx),
    .grant_vld (rr_grant_vld)
  );

  // Pointer moves past the channel just served, so it gets lowest priority next.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (transfer && act_mode == MODE_RR) begin
      rr_ptr <= sel_idx_t'(wrap_inc(int'(grant_idx), N));
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign act_mode    = MODE_EXPLICIT;
`endif

  always_comb begin
    grant_idx = sel;
    grant_vld = sel_in_range && sel_chan_vld;
`ifdef MUX_RR_EN
    if (act_mode == MODE_RR) begin
      grant_idx = rr_grant_idx;
      grant_vld = rr_grant_vld;
    end
`endif
  end

  // One-hot ready for the granted channel plus the matching data mux.
  // Ready is held low throughout reset.
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == sel_idx_t'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
        if (slot_free && grant_vld && !rst) in_ready[i] = 1'b1;
      end
    end
  end

  assign transfer = |in_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data register is reset as well because out_data has a
      // defined reset value visible to downstream logic.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      sel_err   <= 1'b0;
    end else begin
      if (transfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (act_mode == MODE_EXPLICIT && !sel_in_range) sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_n_to_1_reg
// Self-checking bench for mux_n_to_1_reg. Main instance: N=4, WIDTH=8, driven
// through a reference model and a scoreboard queue. A second instance with N=3
// exercises out-of-range select. Round-robin scenarios are built when
// MUX_RR_EN is defined.
// -----------------------------------------------------------------------------
module tb_mux_n_to_1_reg;

  typedef struct packed {
    logic [1:0] chan;
    logic [7:0] data;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        mode;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3;
  logic        mode3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;
  logic        sel_err3;

  int    n_checks = 0;
  int    n_err    = 0;
  item_t sb[$];

  // Reference model state for the N=4 instance.
  logic       m_valid = 1'b0;
  int         m_ptr   = 0;
  logic [3:0] seen_ready;

  always #5 clk = ~clk;

  mux_n_to_1_reg #(.WIDTH(8), .N(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err)
  );

  mux_n_to_1_reg #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
    .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3),
    .sel_err(sel_err3)
  );

  // One clock cycle of the N=4 instance: predict in_ready on the falling edge,
  // push the predicted transfer, then pop and compare after the rising edge.
  task automatic tick();
    logic       slot, gv, xfer, use_rr, rst_now, rdy_now;
    logic [1:0] c;
    int         g;
    logic [3:0] exp_rdy;
    item_t      exp_item;
    @(negedge clk);
    slot   = !m_valid || out_ready;
    gv     = 1'b0;
    g      = 0;
    use_rr = 1'b0;
`ifdef MUX_RR_EN
    use_rr = mode;
`endif
    if (use_rr) begin
      for (int k = 0; k < 4; k++) begin
        c = 2'(m_ptr + k);
        if (!gv && in_valid[c]) begin
          gv = 1'b1;
          g  = int'(c);
        end
      end
    end else begin
      g  = int'(sel);
      gv = in_valid[sel];
    end
    exp_rdy = (slot && gv && !rst) ? (4'b0001 << g) : 4'b0000;
    seen_ready = in_ready;
    n_checks++;
    if (in_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL in_ready @%0t: got %b expected %b", $time, in_ready, exp_rdy);
    end
    xfer = (exp_rdy != 4'b0000);
    if (xfer) sb.push_back('{chan: 2'(g), data: in_data[g*8 +: 8]});
    rst_now = rst;
    rdy_now = out_ready;
    @(posedge clk);
    #1;
    if (rst_now) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      sb.delete();
    end else if (xfer) begin
      m_valid = 1'b1;
      if (use_rr) m_ptr = (g + 1) % 4;
    end else if (rdy_now) begin
      m_valid = 1'b0;
    end
    n_checks++;
    if (out_valid !== m_valid) begin
      n_err++;
      $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, m_valid);
    end
    if (xfer && sb.size() > 0) begin
      exp_item = sb.pop_front();
      n_checks++;
      if (out_data !== exp_item.data || out_chan !== exp_item.chan) begin
        n_err++;
        $display("FAIL scoreboard @%0t: got chan %0d data %h expected chan %0d data %h",
                 $time, out_chan, out_data, exp_item.chan, exp_item.data);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
    in_data = 32'h44332211; in_valid = 4'hF;
    in_data3 = 24'hCCBBAA; in_valid3 = 3'h7; sel3 = 2'd0; mode3 = 1'b0; out_ready3 = 1'b1;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 4'b0000 || in_ready3 !== 3'b000) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b/%b expected 0000/000", in_ready, in_ready3);
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0 || sel_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%h c=%0d e=%b expected 0 00 0 0",
               out_valid, out_data, out_chan, sel_err);
    end
    n_checks++;
    if (out_valid3 !== 1'b0 || sel_err3 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_dut3: got v=%b e=%b expected 0 0", out_valid3, sel_err3);
    end
    rst = 1'b0; in_valid = 4'h0; in_valid3 = 3'h0;
  endtask

  task automatic test_explicit();
    in_data = 32'h44332211; in_valid = 4'hF; sel = 2'd2; out_ready = 1'b1; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (seen_ready !== 4'b0100 || out_data !== 8'h33 || out_chan !== 2'd2) begin
        n_err++;
        $display("FAIL explicit[%0d]: got rdy=%b d=%h c=%0d expected 0100 33 2",
                 i, seen_ready, out_data, out_chan);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (seen_ready !== 4'b0000 || out_data !== 8'h33 || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL backpressure[%0d]: got rdy=%b d=%h v=%b expected 0000 33 1",
                 i, seen_ready, out_data, out_valid);
      end
    end
    // Drain and fill in the same cycle: fresh data from channel 1, no bubble.
    out_ready = 1'b1; sel = 2'd1;
    tick();
    n_checks++;
    if (seen_ready !== 4'b0010 || out_valid !== 1'b1 || out_data !== 8'h22 || out_chan !== 2'd1) begin
      n_err++;
      $display("FAIL no_bubble: got rdy=%b v=%b d=%h c=%0d expected 0010 1 22 1",
               seen_ready, out_valid, out_data, out_chan);
    end
    // Drain only: out_valid drops, data holds.
    in_valid = 4'h0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h22 || out_chan !== 2'd1) begin
      n_err++;
      $display("FAIL drain_hold: got v=%b d=%h c=%0d expected 0 22 1", out_valid, out_data, out_chan);
    end
  endtask

  task automatic test_boundary();
    // Top channel selected but not valid: no grant.
    sel = 2'd3; in_valid = 4'b0111;
    tick();
    n_checks++;
    if (seen_ready !== 4'b0000 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sel_not_valid: got rdy=%b v=%b expected 0000 0", seen_ready, out_valid);
    end
    in_valid = 4'b1000;
    tick();
    n_checks++;
    if (seen_ready !== 4'b1000 || out_data !== 8'h44 || out_chan !== 2'd3) begin
      n_err++;
      $display("FAIL sel_top: got rdy=%b d=%h c=%0d expected 1000 44 3", seen_ready, out_data, out_chan);
    end
    in_valid = 4'h0;
    tick();
  endtask

  task automatic test_sel_err();
    in_data3 = 24'hCCBBAA; in_valid3 = 3'h7; out_ready3 = 1'b1; mode3 = 1'b0; sel3 = 2'd3;
    tick();
    n_checks++;
    if (in_ready3 !== 3'b000 || out_valid3 !== 1'b0 || sel_err3 !== 1'b1) begin
      n_err++;
      $display("FAIL sel_oob: got rdy=%b v=%b e=%b expected 000 0 1", in_ready3, out_valid3, sel_err3);
    end
    sel3 = 2'd0;
    tick();
    n_checks++;
    if (out_valid3 !== 1'b1 || out_data3 !== 8'hAA || out_chan3 !== 2'd0 || sel_err3 !== 1'b1) begin
      n_err++;
      $display("FAIL sel_err_sticky: got v=%b d=%h c=%0d e=%b expected 1 aa 0 1",
               out_valid3, out_data3, out_chan3, sel_err3);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid3 = 3'h0;
    n_checks++;
    if (sel_err3 !== 1'b0 || out_valid3 !== 1'b0) begin
      n_err++;
      $display("FAIL sel_err_clear: got e=%b v=%b expected 0 0", sel_err3, out_valid3);
    end
  endtask

`ifdef MUX_RR_EN
  task automatic test_rr_fair();
    logic [1:0] exp_all [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] exp_odd [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    mode = 1'b1; out_ready = 1'b1; in_data = 32'h44332211; in_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (out_chan !== exp_all[i]) begin
        n_err++;
        $display("FAIL rr_all[%0d]: got chan %0d expected %0d", i, out_chan, exp_all[i]);
      end
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_chan !== exp_odd[i]) begin
        n_err++;
        $display("FAIL rr_odd[%0d]: got chan %0d expected %0d", i, out_chan, exp_odd[i]);
      end
    end
    in_valid = 4'h0;
    tick();
  endtask

  task automatic test_mid_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_valid: got %b expected 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_chan !== 2'd0 || out_data !== 8'h11) begin
      n_err++;
      $display("FAIL mid_reset_ptr: got chan %0d data %h expected 0 11", out_chan, out_data);
    end
    in_valid = 4'h0; mode = 1'b0;
    tick();
  endtask
`else
  task automatic test_mode_ignored();
    mode = 1'b1; sel = 2'd1; out_ready = 1'b1; in_valid = 4'hF;
    tick();
    n_checks++;
    if (seen_ready !== 4'b0010 || out_chan !== 2'd1 || out_data !== 8'h22) begin
      n_err++;
      $display("FAIL mode_ignored: got rdy=%b c=%0d d=%h expected 0010 1 22", seen_ready, out_chan, out_data);
    end
    in_valid = 4'h0; mode = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    mode = 1'b0; sel = 2'd2; out_ready = 1'b1; in_valid = 4'hF;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_err++;
      $display("FAIL mid_reset_valid: got v=%b d=%h expected 0 00", out_valid, out_data);
    end
    sel = 2'd0;
    tick();
    n_checks++;
    if (out_chan !== 2'd0 || out_data !== 8'h11) begin
      n_err++;
      $display("FAIL mid_reset_resume: got chan %0d data %h expected 0 11", out_chan, out_data);
    end
    in_valid = 4'h0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_explicit();
    test_backpressure();
    test_boundary();
    test_sel_err();
`ifdef MUX_RR_EN
    test_rr_fair();
`else
    test_mode_ignored();
`endif
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
